// File: rtl/ibex_data_mem_responder_pkg.sv
// Shared types and helpers for the Ibex data-port memory responder.
//   mem_resp_t            : response payload carried down the latency pipe
//   LfsrTaps              : feedback taps of the x^16+x^14+x^13+x^11 stall LFSR
//   addr_in_range()       : byte address falls inside the modelled SRAM window
//   secded_inv_39_32_enc(): inverted SECDED(39,32) check bits of a data word
package ibex_mem_resp_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned IntgW = 7;
  localparam int unsigned LfsrW = 16;

  typedef struct packed {
    logic             err;
    logic [DataW-1:0] rdata;
  } mem_resp_t;

  // Bits 15,13,12,10 feed back when shifting left.
  localparam logic [LfsrW-1:0] LfsrTaps = 16'hB400;

  // 33-bit arithmetic so a window ending at 2^32 does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [32:0] w_lo;
    logic [32:0] w_hi;
    logic [32:0] w_a;
    w_a  = {1'b0, addr};
    w_lo = {1'b0, base};
    w_hi = w_lo + (33'(words) << 2);
    return (w_a >= w_lo) && (w_a < w_hi);
  endfunction

  // Check bits only; bits 33/35/37 of the 39-bit codeword are inverted.
  function automatic logic [IntgW-1:0] secded_inv_39_32_enc(input logic [DataW-1:0] d);
    logic [IntgW-1:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c ^ 7'h2A;
  endfunction

endpackage

// File: rtl/ibex_data_mem_responder_if.sv
// Ibex LSU data-port bundle (req/gnt/rvalid protocol).
//   master : core side, drives request fields, receives grant and response
//   slave  : memory side, receives request fields, drives grant and response
interface ibex_data_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [6:0]  data_wdata_intg_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic [6:0]  data_rdata_intg_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_wdata_intg_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_wdata_intg_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o
  );
endinterface

// File: rtl/ibex_data_mem_responder_pipe.sv
// ibex_mem_resp_pipe: fixed-latency, valid-tagged response delay line.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears valid tags only)
//   i_valid/i_resp: response entering in the grant cycle
//   o_valid/o_resp: response leaving Depth cycles later; payload zero when idle
module ibex_mem_resp_pipe
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      i_valid,
  input  mem_resp_t i_resp,
  output logic      o_valid,
  output mem_resp_t o_resp
);

  logic [Depth-1:0] r_valid;
  mem_resp_t        r_resp [Depth];

  // Valid tags: dropped on reset so in-flight responses never surface.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < Depth; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  // Payload: no reset needed, qualified by the valid tag at the output.
  always_ff @(posedge clk_i) begin
    r_resp[0] <= i_resp;
    for (int i = 1; i < Depth; i++) r_resp[i] <= r_resp[i-1];
  end

  assign o_valid = r_valid[Depth-1];
  assign o_resp  = r_valid[Depth-1] ? r_resp[Depth-1] : '0;

endmodule

// File: rtl/ibex_data_mem_responder.sv
// ibex_data_mem_responder: word-addressed SRAM model answering the Ibex data port.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset (memory contents kept)
//   bus    : data-port bundle, slave side (req/gnt request phase,
//            rvalid/rdata/rdata_intg/err response phase)
module ibex_data_mem_responder
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          StallEn        = 1'b0,
  parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  ibex_data_mem_responder_if.slave   bus
);

  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [DataW-1:0] r_mem [MemWords];
  logic [CntW-1:0]  r_outstanding;
  logic [LfsrW-1:0] r_lfsr;

  logic             w_stall;
  logic             w_gnt;
  logic             w_in_range;
  logic             w_intg_ok;
  logic             w_err;
  logic             w_wr_en;
  logic [IdxW-1:0]  w_idx;
  mem_resp_t        w_resp_in;
  mem_resp_t        w_resp_out;
  logic             w_rvalid;

  // Request decode and grant; gnt is held low throughout reset.
  assign w_stall    = StallEn && (r_lfsr[1:0] == 2'b00);
  assign w_gnt      = rst_ni && bus.data_req_i &&
                      (r_outstanding < CntW'(MaxOutstanding)) && !w_stall;
  assign w_in_range = addr_in_range(bus.data_addr_i, BaseAddr, MemWords);
  assign w_intg_ok  = (bus.data_wdata_intg_i == secded_inv_39_32_enc(bus.data_wdata_i));
  assign w_err      = !w_in_range || (bus.data_we_i && !w_intg_ok);
  assign w_idx      = IdxW'((bus.data_addr_i - BaseAddr) >> 2);
  assign w_wr_en    = w_gnt && bus.data_we_i && !w_err;

  // Read data is captured in the grant cycle, ahead of this cycle's write.
  assign w_resp_in.err   = w_err;
  assign w_resp_in.rdata = (bus.data_we_i || w_err) ? '0 : r_mem[w_idx];

  // Byte-masked write port.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) r_mem[w_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
      end
    end
  end

  // Stall LFSR, free-running once out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_lfsr <= LfsrSeed;
    else         r_lfsr <= {r_lfsr[LfsrW-2:0], ^(r_lfsr & LfsrTaps)};
  end

  // Granted-but-unanswered count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + CntW'(1);
        2'b01:   r_outstanding <= r_outstanding - CntW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      assert (r_outstanding <= CntW'(MaxOutstanding));
      assert (!(w_gnt && !w_rvalid && (r_outstanding == CntW'(MaxOutstanding))));
      assert (!(w_rvalid && !w_gnt && (r_outstanding == '0)));
    end
  end

  ibex_mem_resp_pipe #(
    .Depth (RespLatency)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_valid (w_gnt),
    .i_resp  (w_resp_in),
    .o_valid (w_rvalid),
    .o_resp  (w_resp_out)
  );

  assign bus.data_gnt_o        = w_gnt;
  assign bus.data_rvalid_o     = w_rvalid;
  assign bus.data_rdata_o      = w_resp_out.rdata;
  assign bus.data_err_o        = w_resp_out.err;
  assign bus.data_rdata_intg_o = secded_inv_39_32_enc(w_resp_out.rdata);

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Bench for ibex_data_mem_responder: three instances (latency 1, latency 3,
// latency 2 with LFSR stalls) driven through one shared stimulus path and
// checked cycle by cycle against a transaction-level reference model.
module tb_ibex_data_mem_responder;

  localparam logic [31:0] Base = 32'h0010_0000;
  localparam logic [31:0] H [7] = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA,
                                    32'h3123_4ED1, 32'hC2C1_323B, 32'h2DCC_624C,
                                    32'h9850_5586};

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  intg;
    int          gap;
  } txn_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          sel    = 0;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic [6:0]  d_intg;
  logic [15:0] m_lfsr;

  txn_t        txq [$];
  exp_t        pend [$];
  logic [31:0] mmem [int];

  ibex_data_mem_responder_if if_a ();
  ibex_data_mem_responder_if if_b ();
  ibex_data_mem_responder_if if_c ();

  assign if_a.data_req_i = d_req && (sel == 0);
  assign if_b.data_req_i = d_req && (sel == 1);
  assign if_c.data_req_i = d_req && (sel == 2);
  assign if_a.data_we_i = d_we;   assign if_b.data_we_i = d_we;   assign if_c.data_we_i = d_we;
  assign if_a.data_be_i = d_be;   assign if_b.data_be_i = d_be;   assign if_c.data_be_i = d_be;
  assign if_a.data_addr_i = d_addr; assign if_b.data_addr_i = d_addr; assign if_c.data_addr_i = d_addr;
  assign if_a.data_wdata_i = d_wdata; assign if_b.data_wdata_i = d_wdata; assign if_c.data_wdata_i = d_wdata;
  assign if_a.data_wdata_intg_i = d_intg; assign if_b.data_wdata_intg_i = d_intg;
  assign if_c.data_wdata_intg_i = d_intg;

  logic        o_gnt, o_rvalid, o_err;
  logic [31:0] o_rdata;
  logic [6:0]  o_intg;
  assign o_gnt    = (sel == 0) ? if_a.data_gnt_o : (sel == 1) ? if_b.data_gnt_o : if_c.data_gnt_o;
  assign o_rvalid = (sel == 0) ? if_a.data_rvalid_o : (sel == 1) ? if_b.data_rvalid_o : if_c.data_rvalid_o;
  assign o_err    = (sel == 0) ? if_a.data_err_o : (sel == 1) ? if_b.data_err_o : if_c.data_err_o;
  assign o_rdata  = (sel == 0) ? if_a.data_rdata_o : (sel == 1) ? if_b.data_rdata_o : if_c.data_rdata_o;
  assign o_intg   = (sel == 0) ? if_a.data_rdata_intg_o :
                    (sel == 1) ? if_b.data_rdata_intg_o : if_c.data_rdata_intg_o;

  ibex_data_mem_responder #(.RespLatency(1), .MaxOutstanding(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_a));
  ibex_data_mem_responder #(.RespLatency(3), .MaxOutstanding(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_b));
  ibex_data_mem_responder #(.MemWords(16), .RespLatency(2), .MaxOutstanding(2),
                            .StallEn(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_c));

  // Stall sequence implied by x^16+x^14+x^13+x^11, restarted from the seed by reset.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] enc_ref(input logic [31:0] d);
    logic [6:0] c;
    for (int r = 0; r < 7; r++) c[r] = ^(d & H[r]);
    return c ^ 7'b010_1010;
  endfunction

  function automatic int lat_of(input int s);  return (s == 0) ? 1 : (s == 1) ? 3 : 2; endfunction
  function automatic int words_of(input int s); return (s == 2) ? 16 : 1024; endfunction

  function automatic txn_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic bad, input int gap);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.gap = gap;
    t.intg = enc_ref(wdata) ^ (bad ? 7'(1 << $urandom_range(0, 6)) : 7'h0);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Play txq on the selected instance and check every cycle against the model.
  task automatic run_txns(input string tag);
    int          cyc;
    int          budget;
    logic        exp_gnt;
    exp_t        e;
    txn_t        t;
    longint      a;
    int          key;
    logic [31:0] w;
    cyc    = 0;
    budget = 60 * txq.size() + 60;
    pend.delete();
    while ((txq.size() != 0 || pend.size() != 0) && cyc < budget) begin
      @(negedge clk);
      d_req = 1'b0;
      if (txq.size() != 0) begin
        t = txq[0];
        if (t.gap > 0) begin
          t.gap--;
          txq[0] = t;
        end else begin
          d_req = 1'b1; d_we = t.we; d_be = t.be; d_addr = t.addr;
          d_wdata = t.wdata; d_intg = t.intg;
        end
      end
      #1;
      exp_gnt = d_req && (pend.size() < 2) && !((sel == 2) && (m_lfsr[1:0] == 2'b00));
      chk({tag, " gnt"}, o_gnt, exp_gnt);
      if (pend.size() != 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        chk({tag, " rvalid"}, o_rvalid, 1'b1);
        chk({tag, " err"}, o_err, e.err);
        chk({tag, " rdata"}, o_rdata, e.rdata);
        chk({tag, " rdata_intg"}, o_intg, enc_ref(e.rdata));
      end else begin
        chk({tag, " rvalid idle"}, o_rvalid, 1'b0);
      end
      if (exp_gnt) begin
        t   = txq.pop_front();
        a   = longint'(t.addr);
        e.due = cyc + lat_of(sel);
        e.err = !(a >= longint'(Base) && a < longint'(Base) + 4 * words_of(sel)) ||
                (t.we && t.intg != enc_ref(t.wdata));
        key = sel * 4096 + int'((a - longint'(Base)) / 4);
        e.rdata = (t.we || e.err) ? 32'h0 : mmem[key];
        if (t.we && !e.err) begin
          w = mmem.exists(key) ? mmem[key] : 32'h0;
          for (int b = 0; b < 4; b++) if (t.be[b]) w[8*b +: 8] = t.wdata[8*b +: 8];
          mmem[key] = w;
        end
        pend.push_back(e);
      end
      cyc++;
    end
    chk({tag, " drained"}, 64'(txq.size() + pend.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0; d_intg = 7'h0;

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset gnt", o_gnt, 1'b0);
      chk("reset rvalid", o_rvalid, 1'b0);
      chk("reset err", o_err, 1'b0);
      chk("reset rdata", o_rdata, 32'h0);
      chk("reset rdata_intg", o_intg, 7'h2A);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle rvalid", o_rvalid, 1'b0);
    chk("idle rdata_intg", o_intg, enc_ref(32'h0));

    // Latency 1: write/read-back, byte merge, range and integrity errors.
    sel = 0;
    txq.push_back(mk(1'b1, 4'hF, Base, 32'hDEAD_BEEF, 1'b0, 0));
    txq.push_back(mk(1'b0, 4'hF, Base, 32'h0, 1'b0, 0));
    run_txns("a_rw");
    txq.push_back(mk(1'b1, 4'b0010, Base, 32'h0000_5500, 1'b0, 0));
    txq.push_back(mk(1'b0, 4'hF, Base, 32'h0, 1'b0, 0));
    run_txns("a_be");
    txq.push_back(mk(1'b0, 4'hF, Base + 32'd4096, 32'h0, 1'b0, 0));
    txq.push_back(mk(1'b0, 4'hF, Base - 32'd4, 32'h0, 1'b0, 1));
    txq.push_back(mk(1'b1, 4'hF, Base, 32'h1234_5678, 1'b1, 0));
    txq.push_back(mk(1'b0, 4'hF, Base + 32'd2, 32'h0, 1'b1, 0));
    txq.push_back(mk(1'b1, 4'hF, Base + 32'd4092, 32'hA5A5_5A5A, 1'b0, 2));
    txq.push_back(mk(1'b0, 4'hF, Base + 32'd4092, 32'h0, 1'b0, 0));
    run_txns("a_err");

    // Latency 3 with two outstanding: held requests, throttled third grant.
    sel = 1;
    for (int i = 0; i < 3; i++)
      txq.push_back(mk(1'b1, 4'hF, Base + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 0));
    run_txns("b_fill");
    for (int i = 0; i < 3; i++) txq.push_back(mk(1'b0, 4'hF, Base + 32'(4 * i), 32'h0, 1'b0, 0));
    run_txns("b_held");

    // Reset one cycle after a grant: that response must never appear.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = Base; d_intg = 7'h0;
    #1;
    chk("b_rst gnt", o_gnt, 1'b1);
    @(negedge clk);
    d_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("b_rst no rvalid", o_rvalid, 1'b0);
    end
    txq.push_back(mk(1'b0, 4'hF, Base + 32'd4, 32'h0, 1'b0, 0));
    txq.push_back(mk(1'b0, 4'hF, Base + 32'd8, 32'h0, 1'b0, 0));
    run_txns("b_post_rst");

    // Stalling instance: fill, then randomized traffic.
    sel = 2;
    for (int i = 0; i < 16; i++)
      txq.push_back(mk(1'b1, 4'hF, Base + 32'(4 * i), $urandom, 1'b0, 0));
    run_txns("c_fill");
    for (int i = 0; i < 200; i++) begin
      logic [31:0] addr;
      int          r;
      r = $urandom_range(0, 9);
      case (r)
        0:       addr = Base - 32'(4 * $urandom_range(1, 4));
        1:       addr = Base + 32'd64 + 32'(4 * $urandom_range(0, 3));
        2:       addr = $urandom;
        default: addr = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
      txq.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr, $urandom,
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0) ? 1 : 0));
    end
    run_txns("c_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
